// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequencing controller for a two-stage digit-counter cascade
// (units stage 0, tens stage 1) forming a 00..(MOD1-1)(MOD0-1) stopwatch.
// A prescaler turns the system clock into count ticks while running; on each
// tick the stage counts read back on d0/d1 decide between incrementing stage 0,
// wrapping stage 0 and carrying into stage 1, or wrapping both (overflow).
//
// Ports:
//   NEclk       system clock, all state changes on the falling edge
//   Nreset      asynchronous active-low reset
//   start_stop  debounced level, rising edge toggles run/pause
//   clear       debounced level, requests zeroing (IDLE/PAUSE only)
//   d0, d1      current counts of stage 0 / stage 1
//   en0, en1    one-cycle enables to the stage counters
//   Nclr0/1     one-cycle active-low clears to the stage counters
//   running     high while in RUN
//   tick        one-cycle pulse per prescaled period
//   ovf         sticky full-wrap flag, cleared by CLR or reset
module stopwatch_ctrl #(
  parameter int unsigned PRESC   = 10,
  parameter int unsigned PRESC_W = 4,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned MOD0    = 10,
  parameter int unsigned MOD1    = 6
) (
  input  logic               NEclk,
  input  logic               Nreset,
  input  logic               start_stop,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] d0,
  input  logic [DIGIT_W-1:0] d1,
  output logic               en0,
  output logic               en1,
  output logic               Nclr0,
  output logic               Nclr1,
  output logic               running,
  output logic               tick,
  output logic               ovf
);

  localparam logic [PRESC_W-1:0] PCNT_LAST = PRESC_W'(PRESC - 1);
  localparam logic [PRESC_W-1:0] PCNT_ONE  = PRESC_W'(1);
  localparam logic [DIGIT_W-1:0] D0_LAST   = DIGIT_W'(MOD0 - 1);
  localparam logic [DIGIT_W-1:0] D1_LAST   = DIGIT_W'(MOD1 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLR   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               prev_ss_q;
  logic               press_c;
  logic               en0_d, en1_d, nclr0_d, nclr1_d, tick_d, ovf_d;

  // Rising-edge detect of the start/stop level.
  assign press_c = start_stop & ~prev_ss_q;

  // Next state, prescaler and next-cycle output pulses.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    en0_d   = 1'b0;
    en1_d   = 1'b0;
    nclr0_d = 1'b1;
    nclr1_d = 1'b1;
    tick_d  = 1'b0;
    ovf_d   = ovf;

    case (state_q)
      // clear takes priority over a simultaneous press when stopped
      IDLE: begin
        if (clear) begin
          state_d = CLR;
        end else if (press_c) begin
          state_d = RUN;
          pcnt_d  = '0;
        end
      end
      // A press on the terminal count holds pcnt, so the tick is deferred
      // to the first RUN cycle after resuming.
      RUN: begin
        if (press_c) begin
          state_d = PAUSE;
        end else if (pcnt_q == PCNT_LAST) begin
          pcnt_d = '0;
          tick_d = 1'b1;
          if (d0 < D0_LAST) begin
            en0_d = 1'b1;
          end else begin
            // out-of-range units also wrap
            nclr0_d = 1'b0;
            if (d1 < D1_LAST) begin
              en1_d = 1'b1;
            end else begin
              nclr1_d = 1'b0;
              ovf_d   = 1'b1;
            end
          end
        end else begin
          pcnt_d = pcnt_q + PCNT_ONE;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d = CLR;
        end else if (press_c) begin
          state_d = RUN;
        end
      end
      CLR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Entering CLR zeroes both stages for exactly the CLR cycle.
    if (state_d == CLR) begin
      nclr0_d = 1'b0;
      nclr1_d = 1'b0;
      pcnt_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  // State and registered outputs, falling-edge clocked.
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      prev_ss_q <= 1'b0;
      en0       <= 1'b0;
      en1       <= 1'b0;
      Nclr0     <= 1'b1;
      Nclr1     <= 1'b1;
      running   <= 1'b0;
      tick      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      prev_ss_q <= start_stop;
      en0       <= en0_d;
      en1       <= en1_d;
      Nclr0     <= nclr0_d;
      Nclr1     <= nclr1_d;
      running   <= (state_d == RUN);
      tick      <= tick_d;
      ovf       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus randomized traffic, with a
// behavioural reference model and an optional emulation of the two counters.
module tb_stopwatch_ctrl;

  localparam int unsigned PRESC   = 10;
  localparam int unsigned PRESC_W = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned MOD0    = 10;
  localparam int unsigned MOD1    = 6;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_CLR   = 3;

  logic               NEclk = 1'b0;
  logic               Nreset = 1'b0;
  logic               start_stop = 1'b0;
  logic               clear = 1'b0;
  logic [DIGIT_W-1:0] d0, d1;
  logic [DIGIT_W-1:0] d0_r = '0, d1_r = '0;
  logic [DIGIT_W-1:0] c0 = '0, c1 = '0;
  logic               use_cnt = 1'b0;
  logic               en0, en1, Nclr0, Nclr1, running, tick, ovf;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 NEclk = ~NEclk;

  assign d0 = use_cnt ? c0 : d0_r;
  assign d1 = use_cnt ? c1 : d1_r;

  stopwatch_ctrl #(
    .PRESC(PRESC), .PRESC_W(PRESC_W), .DIGIT_W(DIGIT_W), .MOD0(MOD0), .MOD1(MOD1)
  ) dut (
    .NEclk(NEclk), .Nreset(Nreset), .start_stop(start_stop), .clear(clear),
    .d0(d0), .d1(d1), .en0(en0), .en1(en1), .Nclr0(Nclr0), .Nclr1(Nclr1),
    .running(running), .tick(tick), .ovf(ovf)
  );

  // Emulated digit counters: enable on the falling edge, clear asynchronously.
  always @(negedge NEclk or negedge Nclr0)
    if (!Nclr0) c0 <= '0; else if (en0) c0 <= c0 + 1'b1;
  always @(negedge NEclk or negedge Nclr1)
    if (!Nclr1) c1 <= '0; else if (en1) c1 <= c1 + 1'b1;

  // Reference model: mode plus count of RUN cycles since the last tick.
  int m_state = M_IDLE;
  int m_ph = 0;
  bit m_prev = 1'b0;
  bit e_en0 = 1'b0, e_en1 = 1'b0, e_nc0 = 1'b1, e_nc1 = 1'b1;
  bit e_run = 1'b0, e_tick = 1'b0, e_ovf = 1'b0;

  always @(negedge NEclk or negedge Nreset) begin : model
    int ns, ph;
    bit pr, t, a0, a1, k0, k1, ov;
    if (!Nreset) begin
      m_state <= M_IDLE; m_ph <= 0; m_prev <= 1'b0;
      e_en0 <= 1'b0; e_en1 <= 1'b0; e_nc0 <= 1'b1; e_nc1 <= 1'b1;
      e_run <= 1'b0; e_tick <= 1'b0; e_ovf <= 1'b0;
    end else begin
      pr = start_stop && !m_prev;
      ns = m_state; ph = m_ph;
      t = 1'b0; a0 = 1'b0; a1 = 1'b0; k0 = 1'b1; k1 = 1'b1; ov = e_ovf;
      if (m_state == M_IDLE) begin
        if (clear) ns = M_CLR;
        else if (pr) begin ns = M_RUN; ph = 0; end
      end else if (m_state == M_RUN) begin
        if (pr) ns = M_PAUSE;
        else begin
          ph = ph + 1;
          if (ph == int'(PRESC)) begin
            ph = 0; t = 1'b1;
            if (int'(d0) < int'(MOD0) - 1) a0 = 1'b1;
            else begin
              k0 = 1'b0;
              if (int'(d1) < int'(MOD1) - 1) a1 = 1'b1;
              else begin k1 = 1'b0; ov = 1'b1; end
            end
          end
        end
      end else if (m_state == M_PAUSE) begin
        if (clear) ns = M_CLR;
        else if (pr) ns = M_RUN;
      end else begin
        ns = M_IDLE;
      end
      if (ns == M_CLR) begin k0 = 1'b0; k1 = 1'b0; ph = 0; ov = 1'b0; end
      m_state <= ns; m_ph <= ph; m_prev <= start_stop;
      e_en0 <= a0; e_en1 <= a1; e_nc0 <= k0; e_nc1 <= k1;
      e_run <= (ns == M_RUN); e_tick <= t; e_ovf <= ov;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge NEclk) begin
    if (chk_en) begin
      checks++;
      if ({en0, en1, Nclr0, Nclr1, running, tick, ovf} !==
          {e_en0, e_en1, e_nc0, e_nc1, e_run, e_tick, e_ovf}) begin
        errors++;
        $display("FAIL model_cycle t=%0t got %b expected %b", $time,
                 {en0, en1, Nclr0, Nclr1, running, tick, ovf},
                 {e_en0, e_en1, e_nc0, e_nc1, e_run, e_tick, e_ovf});
      end
    end
  end

  task automatic press_ss();
    @(posedge NEclk); #1 start_stop = 1'b1;
    @(posedge NEclk); #1 start_stop = 1'b0;
  endtask

  // Returns the number of rising edges until tick is seen (100 = timed out).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge NEclk);
      n++;
    end while (!tick && n < 100);
  endtask

  task automatic test_reset();
    Nreset = 1'b0; start_stop = 1'b0; clear = 1'b0;
    repeat (2) @(posedge NEclk);
    #1;
    checks++;
    if ({en0, en1, Nclr0, Nclr1, running, tick, ovf} !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_values got %b expected %b",
               {en0, en1, Nclr0, Nclr1, running, tick, ovf}, 7'b0011000);
    end
    Nreset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge NEclk);
    #1;
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset running=%b expected 0", running);
    end
  endtask

  task automatic test_first_tick();
    int n;
    use_cnt = 1'b1;
    @(posedge NEclk); #1 clear = 1'b1;
    @(posedge NEclk); #1 clear = 1'b0;
    @(posedge NEclk); #1;
    checks++;
    if ({d1, d0} !== 8'h00) begin
      errors++; $display("FAIL counters_cleared got %h expected 00", {d1, d0});
    end
    press_ss();
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL run_after_press running=%b expected 1", running);
    end
    wait_tick(n);
    checks++;
    if (n != int'(PRESC)) begin
      errors++; $display("FAIL first_tick_latency got %0d expected %0d", n, PRESC);
    end
    checks++;
    if ({en0, en1, Nclr0, Nclr1} !== 4'b1011) begin
      errors++; $display("FAIL first_tick_pulse got %b expected 1011", {en0, en1, Nclr0, Nclr1});
    end
    @(posedge NEclk); #1;
    checks++;
    if (d0 !== 4'd1 || en0 !== 1'b0) begin
      errors++; $display("FAIL first_count d0=%0d en0=%b expected 1 0", d0, en0);
    end
    // Let the cascade run through a carry and compare against decimal arithmetic.
    for (int k = 2; k <= 25; k++) begin
      wait_tick(n);
      @(posedge NEclk); #1;
      checks++;
      if (int'(d0) != k % 10 || int'(d1) != (k / 10) % 6) begin
        errors++;
        $display("FAIL cascade_count tick=%0d got %0d%0d expected %0d%0d",
                 k, d1, d0, (k / 10) % 6, k % 10);
      end
    end
  endtask

  task automatic test_carry();
    int n;
    use_cnt = 1'b0; d0_r = 4'd9; d1_r = 4'd2;
    wait_tick(n);
    checks++;
    if ({en0, en1, Nclr0, Nclr1, ovf} !== 5'b01010) begin
      errors++; $display("FAIL carry_pulse got %b expected 01010", {en0, en1, Nclr0, Nclr1, ovf});
    end
  endtask

  task automatic test_ovf();
    int n;
    d0_r = 4'd9; d1_r = 4'd5;
    wait_tick(n);
    checks++;
    if ({en0, en1, Nclr0, Nclr1, ovf} !== 5'b00001) begin
      errors++; $display("FAIL wrap_pulse got %b expected 00001", {en0, en1, Nclr0, Nclr1, ovf});
    end
    @(posedge NEclk); #1;
    checks++;
    if ({Nclr0, Nclr1, ovf} !== 3'b111) begin
      errors++; $display("FAIL ovf_sticky got %b expected 111", {Nclr0, Nclr1, ovf});
    end
  endtask

  task automatic test_pause_resume();
    int n, k;
    bit bad;
    d0_r = 4'd0; d1_r = 4'd0;
    k = 0;
    do begin
      @(posedge NEclk); #1; k++;
    end while (!(m_state == M_RUN && m_ph == 4) && k < 50);
    start_stop = 1'b1;
    @(posedge NEclk); #1 start_stop = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge NEclk); #1;
      if (tick || en0 || en1 || !Nclr0 || !Nclr1 || running) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL quiet_in_pause saw activity got 1 expected 0");
    end
    press_ss();
    wait_tick(n);
    checks++;
    if (n != int'(PRESC) - 4) begin
      errors++; $display("FAIL resume_latency got %0d expected %0d", n, PRESC - 4);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_through_pause ovf=%b expected 1", ovf);
    end
  endtask

  task automatic test_clear_in_pause();
    press_ss();
    @(posedge NEclk); #1 start_stop = 1'b1; clear = 1'b1;
    @(posedge NEclk); #1;
    checks++;
    if ({Nclr0, Nclr1, ovf, running, en0, en1} !== 6'b000000) begin
      errors++; $display("FAIL clr_cycle got %b expected 000000", {Nclr0, Nclr1, ovf, running, en0, en1});
    end
    start_stop = 1'b0; clear = 1'b0;
    @(posedge NEclk); #1;
    checks++;
    if ({Nclr0, Nclr1, running} !== 3'b110) begin
      errors++; $display("FAIL idle_after_clr got %b expected 110", {Nclr0, Nclr1, running});
    end
  endtask

  task automatic test_clear_in_run();
    bit bad;
    d0_r = 4'd0; d1_r = 4'd0;
    press_ss();
    clear = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge NEclk); #1;
      if (!running || !Nclr1) bad = 1'b1;
    end
    clear = 1'b0;
    checks++;
    if (bad) begin
      errors++; $display("FAIL clear_ignored_in_run got 1 expected 0");
    end
  endtask

  task automatic test_async_reset();
    int n;
    d0_r = 4'd3;
    wait_tick(n);
    checks++;
    if (en0 !== 1'b1) begin
      errors++; $display("FAIL pre_reset_pulse en0=%b expected 1", en0);
    end
    #2 Nreset = 1'b0;
    #1;
    checks++;
    if ({en0, en1, Nclr0, Nclr1, running, tick, ovf} !== 7'b0011000) begin
      errors++;
      $display("FAIL async_reset got %b expected 0011000",
               {en0, en1, Nclr0, Nclr1, running, tick, ovf});
    end
    @(posedge NEclk); #1 Nreset = 1'b1;
    repeat (2) @(posedge NEclk);
    #1;
    checks++;
    if ({running, tick} !== 2'b00) begin
      errors++; $display("FAIL idle_after_release got %b expected 00", {running, tick});
    end
  endtask

  task automatic test_random();
    use_cnt = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(posedge NEclk); #1;
      if ($urandom_range(0, 3) == 0) start_stop = ~start_stop;
      clear = ($urandom_range(0, 24) == 0);
      d0_r = DIGIT_W'($urandom_range(0, 15));
      d1_r = DIGIT_W'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        Nreset = 1'b0;
        #2 Nreset = 1'b1;
      end
    end
    start_stop = 1'b0; clear = 1'b0;
    repeat (2) @(posedge NEclk);
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_carry();
    test_ovf();
    test_pause_resume();
    test_clear_in_pause();
    test_clear_in_run();
    test_async_reset();
    test_random();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
